// File: rtl/yc_line_sequencer.sv
// Line timing controller for the YC encoder: qualifies hsync period with a lock FSM
// and produces burst/chroma gates, PAL line alternation and per-field phase reset.
module yc_line_sequencer #(
  parameter int CNT_W      = 12,
  parameter int TOL        = 4,
  parameter int LOCK_LINES = 8,
  parameter int MISS_LIMIT = 4,
  parameter int GUARD      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pal_en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [CNT_W-1:0] burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             burst_gate,
  output logic             chroma_gate,
  output logic             pal_flip,
  output logic             phase_reset,
  output logic             locked,
  output logic [CNT_W-1:0] line_len
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int MATCH_W = $clog2(LOCK_LINES + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);

  state_t             state;
  logic               hs_r, vs_r;
  logic [CNT_W-1:0]   per, pos, ref_len;
  logic [MATCH_W-1:0] match_cnt;
  logic [MISS_W-1:0]  miss_cnt;

  logic               rise, fall, vrise, timeout, in_tol;
  logic [CNT_W-1:0]   diff;
  logic [MATCH_W-1:0] match_next;
  logic [MISS_W-1:0]  miss_next;
  logic [CNT_W+1:0]   burst_end, chroma_start;
  logic               gate_ok;

  assign rise    = hsync & ~hs_r;
  assign fall    = ~hsync & hs_r;
  assign vrise   = vsync & ~vs_r;
  assign timeout = (per == CNT_MAX);

  // per holds the running period, so on a rise it is this line's length
  assign diff       = (per >= ref_len) ? (per - ref_len) : (ref_len - per);
  assign in_tol     = (diff <= CNT_W'(TOL));
  assign match_next = match_cnt + MATCH_W'(1);
  assign miss_next  = miss_cnt + MISS_W'(1);

  // Window bounds use extra headroom bits so large offsets never wrap around
  assign burst_end    = {2'b00, burst_start} + {2'b00, burst_len};
  assign chroma_start = burst_end + (CNT_W+2)'(GUARD);
  assign gate_ok      = locked & ~vs_r & ~hs_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_r <= 1'b0;
      vs_r <= 1'b0;
      per  <= '0;
      pos  <= '0;
    end else begin
      hs_r <= hsync;
      vs_r <= vsync;
      if (rise)
        per <= CNT_W'(1);
      else if (!timeout)
        per <= per + CNT_W'(1);
      if (fall)
        pos <= '0;
      else if (!hsync && pos != CNT_MAX)
        pos <= pos + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      ref_len   <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      line_len  <= '0;
    end else begin
      case (state)
        SEARCH: begin
          ref_len   <= '0;
          match_cnt <= '0;
          miss_cnt  <= '0;
          locked    <= 1'b0;
          if (rise)
            state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            ref_len   <= per;
            line_len  <= per;
            match_cnt <= '0;
            state     <= VERIFY;
          end else if (timeout) begin
            state <= SEARCH;
          end
        end
        VERIFY: begin
          if (rise) begin
            line_len <= per;
            if (in_tol) begin
              match_cnt <= match_next;
              if (match_next == MATCH_W'(LOCK_LINES)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              ref_len   <= per;
              match_cnt <= '0;
            end
          end else if (timeout) begin
            state <= SEARCH;
          end
        end
        LOCKED: begin
          // Reference stays frozen here so slow drift cannot walk the lock away
          if (rise) begin
            line_len <= per;
            if (in_tol) begin
              miss_cnt <= '0;
            end else if (miss_next == MISS_W'(MISS_LIMIT)) begin
              state  <= SEARCH;
              locked <= 1'b0;
            end else begin
              miss_cnt <= miss_next;
            end
          end else if (timeout) begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_gate  <= 1'b0;
      chroma_gate <= 1'b0;
      pal_flip    <= 1'b0;
      phase_reset <= 1'b0;
    end else begin
      burst_gate  <= gate_ok & (pos >= burst_start) &
                     ({2'b00, pos} < burst_end);
      chroma_gate <= gate_ok & ({2'b00, pos} >= chroma_start);
      phase_reset <= vrise;
      if (!pal_en || vrise)
        pal_flip <= 1'b0;
      else if (rise && !vs_r)
        pal_flip <= ~pal_flip;
    end
  end

endmodule

// File: tb/tb_yc_line_sequencer.sv
// Directed bench for yc_line_sequencer: lock, burst/chroma windows, jitter,
// timeout, PAL sequencing and async reset, with hand-computed expectations.
module tb_yc_line_sequencer;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             pal_en = 1'b0;
  logic             hsync = 1'b0;
  logic             vsync = 1'b0;
  logic [CNT_W-1:0] burst_start = 12'd40;
  logic [CNT_W-1:0] burst_len = 12'd100;
  logic             burst_gate, chroma_gate, pal_flip, phase_reset, locked;
  logic [CNT_W-1:0] line_len;

  int n_cmp = 0;
  int n_fail = 0;

  yc_line_sequencer #(
    .CNT_W(CNT_W), .TOL(4), .LOCK_LINES(8), .MISS_LIMIT(4), .GUARD(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal_en(pal_en), .hsync(hsync), .vsync(vsync),
    .burst_start(burst_start), .burst_len(burst_len),
    .burst_gate(burst_gate), .chroma_gate(chroma_gate), .pal_flip(pal_flip),
    .phase_reset(phase_reset), .locked(locked), .line_len(line_len)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_rise();
    hsync = 1'b1;
    step();
  endtask

  task automatic hs_hold(input int n, input logic v);
    hsync = v;
    repeat (n) step();
  endtask

  // Remainder of a line after its rising edge: 64 clocks high total, p clocks rise-to-rise
  task automatic line_body(input int p);
    hs_hold(63, 1'b1);
    hs_hold(p - 64, 1'b0);
  endtask

  // Ten rises from SEARCH: lock must appear exactly on the tenth
  task automatic relock(input string tag);
    for (int r = 1; r <= 10; r++) begin
      hs_rise();
      if (r >= 9) begin
        n_cmp++;
        if (locked !== (r == 10)) begin
          n_fail++;
          $display("[TB] FAIL %s_rise%0d: locked=%b expected %b", tag, r, locked, (r == 10));
        end
      end
      if (r == 10) begin
        n_cmp++;
        if (line_len !== 12'd1000) begin
          n_fail++;
          $display("[TB] FAIL %s_line_len: got %0d expected 1000", tag, line_len);
        end
      end
      line_body(1000);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({burst_gate, chroma_gate, pal_flip, phase_reset, locked} !== 5'b0 || line_len !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: bits=%b line_len=%0d expected all 0",
               {burst_gate, chroma_gate, pal_flip, phase_reset, locked}, line_len);
    end
    reset_n = 1'b1;
    hs_hold(20, 1'b0);
  endtask

  task automatic test_lock();
    relock("lock");
  endtask

  task automatic test_burst();
    int first_b, last_b, cnt_b, first_c;
    logic overlap;
    first_b = 0; last_b = 0; cnt_b = 0; first_c = 0; overlap = 1'b0;
    hs_rise();
    hs_hold(63, 1'b1);
    hsync = 1'b0;
    for (int k = 1; k <= 936; k++) begin
      step();
      if (burst_gate) begin
        cnt_b++;
        if (first_b == 0) first_b = k;
        last_b = k;
      end
      if (chroma_gate && first_c == 0) first_c = k;
      if (burst_gate && chroma_gate) overlap = 1'b1;
    end
    n_cmp++;
    if (cnt_b != 100) begin n_fail++; $display("[TB] FAIL burst_count: got %0d expected 100", cnt_b); end
    n_cmp++;
    if (first_b != 42) begin n_fail++; $display("[TB] FAIL burst_first: got %0d expected 42", first_b); end
    n_cmp++;
    if (last_b != 141) begin n_fail++; $display("[TB] FAIL burst_last: got %0d expected 141", last_b); end
    n_cmp++;
    if (first_c != 158) begin n_fail++; $display("[TB] FAIL chroma_first: got %0d expected 158", first_c); end
    n_cmp++;
    if (overlap !== 1'b0) begin n_fail++; $display("[TB] FAIL gate_overlap: got %b expected 0", overlap); end
    n_cmp++;
    if (chroma_gate !== 1'b1) begin n_fail++; $display("[TB] FAIL chroma_line_end: got %b expected 1", chroma_gate); end
    hs_rise();
    hs_hold(1, 1'b1);
    n_cmp++;
    if (chroma_gate !== 1'b0) begin n_fail++; $display("[TB] FAIL chroma_after_hs: got %b expected 0", chroma_gate); end
    hs_hold(62, 1'b1);
    hs_hold(936, 1'b0);
  endtask

  task automatic test_jitter();
    int bodies [12] = '{998, 1003, 998, 1003, 1010, 1010, 1010, 1000, 1010, 1010, 1010, 1010};
    for (int i = 0; i <= 12; i++) begin
      hs_rise();
      if (i > 0) begin
        n_cmp++;
        if (locked !== (i < 12)) begin
          n_fail++;
          $display("[TB] FAIL jitter_locked_r%0d: got %b expected %b", i, locked, (i < 12));
        end
        n_cmp++;
        if (line_len !== 12'(bodies[i-1])) begin
          n_fail++;
          $display("[TB] FAIL jitter_len_r%0d: got %0d expected %0d", i, line_len, bodies[i-1]);
        end
      end
      line_body((i < 12) ? bodies[i] : 1000);
    end
    n_cmp++;
    if (chroma_gate !== 1'b0) begin n_fail++; $display("[TB] FAIL jitter_chroma_unlocked: got %b expected 0", chroma_gate); end
  endtask

  task automatic test_timeout();
    relock("prelock");
    n_cmp++;
    if (chroma_gate !== 1'b1) begin n_fail++; $display("[TB] FAIL timeout_pre_chroma: got %b expected 1", chroma_gate); end
    hs_hold(4100, 1'b0);
    n_cmp++;
    if ({locked, burst_gate, chroma_gate} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL timeout_drop: locked/burst/chroma=%b expected 000", {locked, burst_gate, chroma_gate});
    end
    relock("timeout_relock");
  endtask

  task automatic test_pal();
    logic exp_flip [3] = '{1'b1, 1'b0, 1'b1};
    pal_en = 1'b1;
    hs_rise();
    n_cmp++;
    if (pal_flip !== 1'b1) begin n_fail++; $display("[TB] FAIL pal_pre_vsync: got %b expected 1", pal_flip); end
    hs_hold(63, 1'b1);
    hs_hold(100, 1'b0);
    vsync = 1'b1;
    step();
    n_cmp++;
    if ({phase_reset, pal_flip} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL pal_vrise: phase_reset/pal_flip=%b expected 10", {phase_reset, pal_flip});
    end
    step();
    n_cmp++;
    if (phase_reset !== 1'b0) begin n_fail++; $display("[TB] FAIL phase_reset_width: got %b expected 0", phase_reset); end
    vsync = 1'b0;
    hs_hold(834, 1'b0);
    for (int i = 0; i < 3; i++) begin
      hs_rise();
      n_cmp++;
      if (pal_flip !== exp_flip[i]) begin
        n_fail++;
        $display("[TB] FAIL pal_seq%0d: got %b expected %b", i, pal_flip, exp_flip[i]);
      end
      if (i < 2) line_body(1000);
    end
    pal_en = 1'b0;
    hs_hold(1, 1'b1);
    n_cmp++;
    if (pal_flip !== 1'b0) begin n_fail++; $display("[TB] FAIL pal_disable: got %b expected 0", pal_flip); end
    hs_hold(62, 1'b1);
    hs_hold(936, 1'b0);
    hs_rise();
    n_cmp++;
    if (pal_flip !== 1'b0) begin n_fail++; $display("[TB] FAIL pal_ntsc_hold: got %b expected 0", pal_flip); end
    n_cmp++;
    if (locked !== 1'b1) begin n_fail++; $display("[TB] FAIL pal_still_locked: got %b expected 1", locked); end
    line_body(1000);
  endtask

  task automatic test_async_reset();
    hs_rise();
    hs_hold(63, 1'b1);
    hs_hold(60, 1'b0);
    n_cmp++;
    if (burst_gate !== 1'b1) begin n_fail++; $display("[TB] FAIL areset_pre_burst: got %b expected 1", burst_gate); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({burst_gate, chroma_gate, pal_flip, phase_reset, locked} !== 5'b0 || line_len !== '0) begin
      n_fail++;
      $display("[TB] FAIL areset_immediate: bits=%b line_len=%0d expected all 0",
               {burst_gate, chroma_gate, pal_flip, phase_reset, locked}, line_len);
    end
    step();
    step();
    reset_n = 1'b1;
    hs_hold(874, 1'b0);
    relock("areset_relock");
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_lock();
    test_burst();
    test_jitter();
    test_timeout();
    test_pal();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
